// File: rtl/alu_cmd_pkg.sv
// Shared types and function codes for the ALU command queue.
// cmd_t is one queued {func, data} entry.
package alu_cmd_pkg;

  localparam int CMD_DW = 4;
  localparam int CMD_FW = 2;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_MUL  = 2'b01;
  localparam logic [1:0] FN_SHL  = 2'b10;
  localparam logic [1:0] FN_HOLD = 2'b11;

  typedef struct packed {
    logic [1:0] func;
    logic [3:0] data;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Command-queue bus: key/switch inputs plus ALU-side and status outputs.
// master drives Push/PushData/PushFunc/Run/Step; slave is the queue.
interface alu_cmd_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4,
  parameter int FUNC_W = 2
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              Push;
  logic [DATA_W-1:0] PushData;
  logic [FUNC_W-1:0] PushFunc;
  logic              Run;
  logic              Step;
  logic [DATA_W-1:0] Data;
  logic [FUNC_W-1:0] Function;
  logic [CW-1:0]     Count;
  logic              Full;
  logic              Empty;
  logic              Overflow;

  modport master (
    output Push, PushData, PushFunc, Run, Step,
    input  Data, Function, Count, Full, Empty, Overflow
  );

  modport slave (
    input  Push, PushData, PushFunc, Run, Step,
    output Data, Function, Count, Full, Empty, Overflow
  );

endinterface

// File: rtl/key_edge.sv
// Rising-edge pulse from a synchronous, debounced key level.
// Ports: Clock, Reset_b (async, active-high), key in, evt one-cycle pulse.
module key_edge (
  input  logic Clock,
  input  logic Reset_b,
  input  logic key,
  output logic evt
);

  logic key_q;

  // History resets to 1 so a key held through reset is not an event.
  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) key_q <= 1'b1;
    else         key_q <= key;
  end

  assign evt = key & ~key_q;

endmodule

// File: rtl/alu_cmd_queue.sv
// Captures {func,data} commands into a FIFO and replays them to the ALU.
// Ports: Clock, Reset_b (async, active-high), q (alu_cmd_queue_if.slave).
module alu_cmd_queue
  import alu_cmd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = CMD_DW,
  parameter int FUNC_W = CMD_FW
) (
  input logic            Clock,
  input logic            Reset_b,
  alu_cmd_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  cmd_t mem [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [DATA_W-1:0] data_q;
  logic [FUNC_W-1:0] func_q;
  logic              ovf_q;

  logic push_evt;
  logic step_evt;
  logic full;
  logic empty;
  logic pop_req;
  logic pop_ok;
  logic push_ok;

  key_edge u_push (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .key     (q.Push),
    .evt     (push_evt)
  );

  key_edge u_step (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .key     (q.Step),
    .evt     (step_evt)
  );

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // No bypass: a pop only ever sees entries already stored.
  assign pop_req = q.Run | (step_evt & ~q.Run);
  assign pop_ok  = pop_req & ~empty;
  assign push_ok = push_evt & (~full | pop_ok);

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      (push_ok & ~pop_ok): count_nxt = count + 1'b1;
      (pop_ok & ~push_ok): count_nxt = count - 1'b1;
      default:             count_nxt = count;
    endcase
  end

  // Storage is not reset; contents are don't-care until written.
  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{func: q.PushFunc, data: q.PushData};
    end
  end

  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push_ok)             wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)              rd_ptr <= rd_ptr + 1'b1;
      if (push_evt & ~push_ok) ovf_q  <= 1'b1;
    end
  end

  // Each popped command is shown for exactly one clock, else hold.
  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      func_q <= FN_HOLD;
      data_q <= '0;
    end else if (pop_ok) begin
      func_q <= mem[rd_ptr].func;
      data_q <= mem[rd_ptr].data;
    end else begin
      func_q <= FN_HOLD;
      data_q <= '0;
    end
  end

  assign q.Data     = data_q;
  assign q.Function = func_q;
  assign q.Count    = count;
  assign q.Full     = full;
  assign q.Empty    = empty;
  assign q.Overflow = ovf_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_alu_cmd_queue;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   acc;

  alu_cmd_queue_if #(.DEPTH(4), .DATA_W(4), .FUNC_W(2)) bus ();

  alu_cmd_queue #(.DEPTH(4), .DATA_W(4), .FUNC_W(2)) dut (
    .Clock   (clk),
    .Reset_b (rst),
    .q       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp_cmd(input string tag, input int f, input int d);
    chk({tag, ".func"}, int'(bus.Function), f);
    chk({tag, ".data"}, int'(bus.Data), d);
  endtask

  task automatic push(input logic [1:0] f, input logic [3:0] d);
    bus.PushFunc = f;
    bus.PushData = d;
    bus.Push     = 1'b1;
    tick();
    bus.Push     = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Downstream ALU model fed with what the queue presents.
  task automatic alu_apply();
    case (bus.Function)
      2'b00:   acc = acc + int'(bus.Data);
      2'b01:   acc = acc * int'(bus.Data);
      2'b10:   acc = acc << bus.Data;
      default: acc = acc;
    endcase
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    acc   = 0;
    rst          = 1'b0;
    bus.Push     = 1'b1;
    bus.PushData = 4'd5;
    bus.PushFunc = 2'b00;
    bus.Run      = 1'b0;
    bus.Step     = 1'b0;

    // Reset asserted mid-cycle with Push held high.
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst.count", int'(bus.Count), 0);
    chk("rst.empty", int'(bus.Empty), 1);
    chk("rst.ovf", int'(bus.Overflow), 0);
    exp_cmd("rst", 3, 0);
    bus.Push = 1'b0;
    tick();
    chk("rst.noenq", int'(bus.Count), 0);

    // Fill and drain by Step.
    push(2'b00, 4'd3);
    push(2'b01, 4'd2);
    push(2'b10, 4'd1);
    chk("fill.count", int'(bus.Count), 3);
    for (int i = 0; i < 3; i++) begin
      bus.Step = 1'b1;
      tick();
      alu_apply();
      case (i)
        0: begin exp_cmd("step0", 0, 3); chk("acc0", acc, 3);  end
        1: begin exp_cmd("step1", 1, 2); chk("acc1", acc, 6);  end
        default: begin exp_cmd("step2", 2, 1); chk("acc2", acc, 12); end
      endcase
      bus.Step = 1'b0;
      tick();
      exp_cmd("step.hold", 3, 0);
    end
    chk("drain.empty", int'(bus.Empty), 1);

    // Overflow: five pushes into four slots.
    push(2'b00, 4'd1);
    push(2'b01, 4'd2);
    push(2'b10, 4'd3);
    push(2'b00, 4'd4);
    push(2'b01, 4'd5);
    chk("ovf.count", int'(bus.Count), 4);
    chk("ovf.full", int'(bus.Full), 1);
    chk("ovf.flag", int'(bus.Overflow), 1);
    bus.Run = 1'b1;
    tick(); exp_cmd("run0", 0, 1);
    tick(); exp_cmd("run1", 1, 2);
    tick(); exp_cmd("run2", 2, 3);
    tick(); exp_cmd("run3", 0, 4);
    tick(); exp_cmd("run.hold", 3, 0);
    chk("run.empty", int'(bus.Empty), 1);
    chk("ovf.sticky", int'(bus.Overflow), 1);
    bus.Run = 1'b0;

    // Simultaneous push and pop while full.
    do_reset();
    push(2'b00, 4'd1);
    push(2'b01, 4'd2);
    push(2'b10, 4'd3);
    push(2'b00, 4'd4);
    chk("pf.full", int'(bus.Full), 1);
    bus.PushFunc = 2'b10;
    bus.PushData = 4'd7;
    bus.Push     = 1'b1;
    bus.Run      = 1'b1;
    tick();
    chk("pf.count", int'(bus.Count), 4);
    chk("pf.ovf", int'(bus.Overflow), 0);
    exp_cmd("pf.out", 0, 1);
    bus.Push = 1'b0;
    bus.Run  = 1'b0;
    tick();
    chk("pf.count2", int'(bus.Count), 4);
    exp_cmd("pf.hold", 3, 0);
    bus.Run = 1'b1;
    tick(); exp_cmd("pf.d0", 1, 2);
    tick(); exp_cmd("pf.d1", 2, 3);
    tick(); exp_cmd("pf.d2", 0, 4);
    tick(); exp_cmd("pf.d3", 2, 7);
    tick(); exp_cmd("pf.end", 3, 0);
    bus.Run = 1'b0;

    // Empty-edge cases.
    bus.Step = 1'b1;
    tick();
    chk("es.count", int'(bus.Count), 0);
    exp_cmd("es.out", 3, 0);
    bus.Step = 1'b0;
    tick();
    bus.PushFunc = 2'b01;
    bus.PushData = 4'd9;
    bus.Push     = 1'b1;
    bus.Run      = 1'b1;
    tick();
    chk("pe.count", int'(bus.Count), 1);
    exp_cmd("pe.nobyp", 3, 0);
    bus.Push = 1'b0;
    tick();
    chk("pe.count2", int'(bus.Count), 0);
    exp_cmd("pe.out", 1, 9);
    bus.Run = 1'b0;
    tick();
    exp_cmd("pe.hold", 3, 0);

    // Wrap-around from a known pointer origin.
    do_reset();
    push(2'b00, 4'd10);
    push(2'b01, 4'd11);
    push(2'b10, 4'd12);
    push(2'b00, 4'd13);
    bus.Step = 1'b1; tick(); exp_cmd("wr.s0", 0, 10);
    bus.Step = 1'b0; tick();
    bus.Step = 1'b1; tick(); exp_cmd("wr.s1", 1, 11);
    bus.Step = 1'b0; tick();
    push(2'b10, 4'd14);
    push(2'b11, 4'd15);
    chk("wr.count", int'(bus.Count), 4);
    chk("wr.ovf", int'(bus.Overflow), 0);
    bus.Run = 1'b1;
    tick(); exp_cmd("wr.d0", 2, 12);
    tick(); exp_cmd("wr.d1", 0, 13);
    tick(); exp_cmd("wr.d2", 2, 14);
    tick(); exp_cmd("wr.d3", 3, 15);
    tick(); exp_cmd("wr.end", 3, 0);
    bus.Run = 1'b0;

    // Asynchronous reset while a command is on the output.
    push(2'b01, 4'd6);
    push(2'b00, 4'd2);
    bus.Run = 1'b1;
    tick();
    exp_cmd("ar.pre", 1, 6);
    #2 rst = 1'b1;
    #1;
    chk("ar.count", int'(bus.Count), 0);
    exp_cmd("ar.out", 3, 0);
    bus.Run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
Upstream command stage for the lab4 accumulator ALU. It captures {Function, Data} commands from switches on a key press into a small FIFO. It replays them into the ALU one per clock (Run) or one per key press (Step). When idle it drives the ALU hold code (2'b11), so the accumulator is unchanged between issued commands.

Parameters:
DEPTH, 4, number of queued commands; power of two, at least 2.
DATA_W, 4, operand width; matches the ALU Data input.
FUNC_W, 2, function code width; matches the ALU Function input.

Ports:
Clock  input  1  system clock; all state changes on posedge.
Reset_b  input  1  asynchronous, active-high reset (asserted = 1).
Push  input  1  enqueue key, level; its rising edge requests one enqueue.
PushData  input  DATA_W  operand to enqueue; sampled in the Push edge cycle.
PushFunc  input  FUNC_W  function code to enqueue; sampled with PushData.
Run  input  1  level; while 1, pop one command per clock when not empty.
Step  input  1  step key, level; its rising edge requests one pop. Ignored while Run=1.
Data  output  DATA_W  registered operand to the ALU.
Function  output  FUNC_W  registered function code to the ALU.
Count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
Full  output  1  Count == DEPTH (combinational from Count).
Empty  output  1  Count == 0 (combinational from Count).
Overflow  output  1  sticky; set when an enqueue is dropped.

Behaviour:
- Reset (async, Reset_b=1): wr_ptr=rd_ptr=0, Count=0, Data=0, Function=2'b11 (hold), Overflow=0.
- Reset also sets the edge-detector history registers to 1, so a key held through reset does not produce an event.
- Queue contents are not cleared by reset; they are don't-care.
- Edge detect: evt = key & ~key_q, with key_q <= key every clock. Each evt is a single-cycle pulse; Push and Step are assumed already synchronous and debounced.
- push_req = Push evt. pop_req = Run | (Step evt & ~Run).
- Accept rules, evaluated in the same cycle:
  - push_ok = push_req & (~Full | pop_ok).
  - pop_ok = pop_req & ~Empty. There is no bypass: an entry pushed this cycle cannot be popped this cycle.
- Push and pop together when Full: both accepted, Count unchanged.
- Push and pop together when Empty: push accepted, pop ignored, Count becomes 1.
- push_req & ~push_ok: the command is dropped and Overflow <= 1. Overflow stays 1 until reset.
- Pop request when Empty: ignored silently; Count stays 0, no flag raised.
- Pointers wrap modulo DEPTH. Count is updated as +1 / -1 / 0 per accepted push and pop.
- Output timing: when pop_ok occurs in cycle n, {Function, Data} show the popped command during cycle n+1.
- If no pop_ok occurs in cycle n, cycle n+1 shows Function=2'b11, Data=0. Each command is therefore presented for exactly one clock; the ALU registers it at the end of that clock.
- With Run=1 and k entries, the queue emits k back-to-back commands followed by hold.
- The queue passes function codes through unchanged; it does not interpret them. Any enqueued 2'b11 is issued as a hold.
- Reset mid-operation: queued commands are lost and the output drops to hold immediately (asynchronously).

Decomposition:
- Package alu_cmd_pkg:
  - Constants FN_ADD=2'b00, FN_MUL=2'b01, FN_SHL=2'b10, FN_HOLD=2'b11.
  - typedef cmd_t as a packed struct {func[1:0], data[3:0]}; the storage array is cmd_t [DEPTH].
- Sub-module key_edge(Clock, Reset_b, key, evt): rising-edge pulse generator, history register reset to 1. Instantiated twice, for Push and Step.

Test Plan:
- Reset: assert Reset_b mid-cycle with Push held high; release -> Count=0, Empty=1, Function=11, Data=0, Overflow=0, and no enqueue occurs from the held key.
- Fill and drain by Step:
  - Push {00,3}, {01,2}, {10,1} -> Count=3.
  - Each Step pulse -> exactly one cycle of (00,3), then (01,2), then (10,1), with hold (11,0) between pulses.
  - Downstream ALU accumulates 3, then 6, then 12.
- Overflow: push 5 commands with Run=0 -> Count=4, Full=1, Overflow=1. Then Run=1 -> 4 consecutive commands issued in push order (the 5th was dropped), then hold, Empty=1.
- Simultaneous push and pop at Full: with Run=1 and Full, a Push edge -> Count stays 4 and Overflow stays 0.
- Empty-edge cases:
  - Step when Empty -> Count=0 and output stays hold.
  - Push and Run together when Empty -> Count=1 in the next cycle; the command is issued one cycle later, never in the push cycle.
- Wrap-around: with Run=0, push 4 and pop 2, then push 2 -> Count=4. Draining yields commands in push order across the pointer wrap.
